// File: rtl/jogo_pkg.sv
// Shared symbols for the one-hot round protocol: FSM state encoding, button symbols and their codes.
package jogo_pkg;

  typedef enum logic [2:0] {
    Idle     = 3'd0,
    Espera   = 3'd1,
    Filtra   = 3'd2,
    Registra = 3'd3,
    Soltar   = 3'd4,
    Esgotado = 3'd5
  } estado_t;

  localparam logic [3:0] BOTAO_0 = 4'b1000;
  localparam logic [3:0] BOTAO_1 = 4'b0100;
  localparam logic [3:0] BOTAO_2 = 4'b0010;
  localparam logic [3:0] BOTAO_3 = 4'b0001;

  localparam logic [1:0] CODIGO_0 = 2'b00;
  localparam logic [1:0] CODIGO_1 = 2'b01;
  localparam logic [1:0] CODIGO_2 = 2'b10;
  localparam logic [1:0] CODIGO_3 = 2'b11;

  function automatic logic one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  // Anything that is not a single pressed button encodes as 00.
  function automatic logic [1:0] codifica(input logic [3:0] v);
    case (v)
      BOTAO_0: return CODIGO_0;
      BOTAO_1: return CODIGO_1;
      BOTAO_2: return CODIGO_2;
      BOTAO_3: return CODIGO_3;
      default: return CODIGO_0;
    endcase
  endfunction

endpackage

// File: rtl/jogada_decoder_if.sv
// Button/target inputs and registered judgement outputs between the player side and the decoder.
interface jogada_decoder_if;

    logic       habilita;
    logic [3:0] botoes;
    logic [3:0] esperado;
    logic [1:0] codigo;
    logic       jogada_valida;
    logic       acertou;
    logic       errou;
    logic       invalida;
    logic       timeout;

    modport master (
        output habilita, botoes, esperado,
        input  codigo, jogada_valida, acertou, errou, invalida, timeout
    );

    modport slave (
        input  habilita, botoes, esperado,
        output codigo, jogada_valida, acertou, errou, invalida, timeout
    );

endinterface

// File: rtl/contador_m.sv
// Modulo-M cycle counter; fim is high on the last count. M = 0 disables fim.
module contador_m #(
    parameter int unsigned M = 1000,
    parameter int unsigned N = 10
) (
    input  logic clock,
    input  logic zera_as,
    input  logic zera_s,
    output logic fim
);

    logic [N-1:0] cnt_q;
    logic         ultimo;

    assign ultimo = (cnt_q == N'(M - 1));
    assign fim    = (M != 0) && ultimo;

    always_ff @(posedge clock or posedge zera_as) begin
        if (zera_as) begin
            cnt_q <= '0;
        end else if (zera_s || ultimo) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + N'(1);
        end
    end

endmodule

// File: rtl/jogada_decoder.sv
// Decodes synchronised player buttons into a 2-bit code and judges each play against the target.
// Optional debounce filter enabled by defining DEBOUNCE_EN.
module jogada_decoder
    import jogo_pkg::*;
#(
    parameter int unsigned TIMEOUT_CICLOS  = 1000,
    parameter int unsigned DEBOUNCE_CICLOS = 8,
    parameter int unsigned N               = 10
) (
    input  logic              clock,
    input  logic              zera_as,
    input  logic              zera_s,
    jogada_decoder_if.slave   bus
);

    estado_t    estado_q, estado_d;
    logic [3:0] b_meta, b_s;
    logic       fim;
    logic       acerto;

    always_ff @(posedge clock or posedge zera_as) begin
        if (zera_as) begin
            b_meta <= '0;
            b_s    <= '0;
        end else if (zera_s) begin
            b_meta <= '0;
            b_s    <= '0;
        end else begin
            b_meta <= bus.botoes;
            b_s    <= b_meta;
        end
    end

    // Timeout only advances while waiting for a press.
    contador_m #(
        .M (TIMEOUT_CICLOS),
        .N (N)
    ) u_timeout (
        .clock   (clock),
        .zera_as (zera_as),
        .zera_s  (zera_s || (estado_q != Espera)),
        .fim     (fim)
    );

`ifdef DEBOUNCE_EN
    logic [N-1:0] deb_cnt_q;
    logic [3:0]   deb_val_q;

    always_ff @(posedge clock or posedge zera_as) begin
        if (zera_as) begin
            deb_cnt_q <= '0;
            deb_val_q <= '0;
        end else if (zera_s || (estado_q != Filtra) || (b_s != deb_val_q)) begin
            deb_cnt_q <= '0;
            deb_val_q <= b_s;
        end else begin
            deb_cnt_q <= deb_cnt_q + N'(1);
        end
    end
`endif

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            Idle:     if (bus.habilita) estado_d = Espera;
            Espera: begin
                if (b_s != 4'b0000) begin
`ifdef DEBOUNCE_EN
                    estado_d = Filtra;
`else
                    estado_d = Registra;
`endif
                end else if (fim) begin
                    estado_d = Esgotado;
                end
            end
`ifdef DEBOUNCE_EN
            Filtra: begin
                if (b_s == 4'b0000) begin
                    estado_d = Espera;
                end else if ((b_s == deb_val_q) && (deb_cnt_q == N'(DEBOUNCE_CICLOS - 1))) begin
                    estado_d = Registra;
                end
            end
`endif
            Registra: estado_d = Soltar;
            Soltar:   if (b_s == 4'b0000) estado_d = Espera;
            Esgotado: estado_d = Espera;
            default:  estado_d = Idle;
        endcase
        // Disabling wins over everything and suppresses any pulse.
        if (!bus.habilita) estado_d = Idle;
    end

    assign acerto = one_hot(b_s) && (b_s == bus.esperado);

    always_ff @(posedge clock or posedge zera_as) begin
        if (zera_as) begin
            estado_q          <= Idle;
            bus.codigo        <= CODIGO_0;
            bus.jogada_valida <= 1'b0;
            bus.acertou       <= 1'b0;
            bus.errou         <= 1'b0;
            bus.invalida      <= 1'b0;
            bus.timeout       <= 1'b0;
        end else if (zera_s) begin
            estado_q          <= Idle;
            bus.codigo        <= CODIGO_0;
            bus.jogada_valida <= 1'b0;
            bus.acertou       <= 1'b0;
            bus.errou         <= 1'b0;
            bus.invalida      <= 1'b0;
            bus.timeout       <= 1'b0;
        end else begin
            estado_q          <= estado_d;
            bus.jogada_valida <= (estado_d == Registra);
            bus.acertou       <= (estado_d == Registra) && acerto;
            bus.errou         <= ((estado_d == Registra) && !acerto) || (estado_d == Esgotado);
            bus.invalida      <= (estado_d == Registra) && !one_hot(b_s);
            bus.timeout       <= (estado_d == Esgotado);
            if ((estado_d == Registra) && (estado_q != Registra)) begin
                bus.codigo <= codifica(b_s);
            end
        end
    end

endmodule

// File: tb/tb_jogada_decoder.sv
// Directed bench for jogada_decoder: main instance plus a short-timeout instance. Honours DEBOUNCE_EN.
module tb_jogada_decoder;

    logic clock;
    logic zera_as;
    logic zera_s;
    int   tests;
    int   fails;
    int   npulsos;

`ifdef DEBOUNCE_EN
    localparam int LAT = 3 + 8;
`else
    localparam int LAT = 3;
`endif

    jogada_decoder_if bus ();
    jogada_decoder_if bus_t ();

    jogada_decoder #(
        .TIMEOUT_CICLOS  (1000),
        .DEBOUNCE_CICLOS (8),
        .N               (10)
    ) dut (
        .clock   (clock),
        .zera_as (zera_as),
        .zera_s  (zera_s),
        .bus     (bus)
    );

    jogada_decoder #(
        .TIMEOUT_CICLOS  (10),
        .DEBOUNCE_CICLOS (8),
        .N               (10)
    ) dut_t (
        .clock   (clock),
        .zera_as (zera_as),
        .zera_s  (zera_s),
        .bus     (bus_t)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Packed as {codigo, jogada_valida, acertou, errou, invalida, timeout}.
    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic count_valid(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(posedge clock);
            #1;
            if (bus.jogada_valida === 1'b1) c++;
        end
    endtask

    function automatic logic [6:0] outs_m();
        return {bus.codigo, bus.jogada_valida, bus.acertou, bus.errou, bus.invalida, bus.timeout};
    endfunction

    function automatic logic [6:0] outs_t();
        return {bus_t.codigo, bus_t.jogada_valida, bus_t.acertou, bus_t.errou, bus_t.invalida,
                bus_t.timeout};
    endfunction

    initial begin
        tests         = 0;
        fails         = 0;
        zera_as       = 1'b1;
        zera_s        = 1'b0;
        bus.habilita  = 1'b0;
        bus.botoes    = 4'b0000;
        bus.esperado  = 4'b0000;
        bus_t.habilita = 1'b0;
        bus_t.botoes   = 4'b0000;
        bus_t.esperado = 4'b0100;
        tick(2);
        chk("reset_in", outs_m(), 7'b00_00000);
        zera_as = 1'b0;
        tick(1);
        chk("reset_out", outs_m(), 7'b00_00000);
        bus.habilita = 1'b1;
        tick(2);

        // Correct press of 0100
        bus.esperado = 4'b0100;
        bus.botoes   = 4'b0100;
        tick(LAT - 1);
        chk("t1_early", outs_m(), 7'b00_00000);
        tick(1);
        chk("t1_pulse", outs_m(), 7'b01_11000);
        tick(1);
        chk("t1_after", outs_m(), 7'b01_00000);
        tick(1);
        bus.botoes = 4'b0000;
        tick(4);
        chk("t1_held", outs_m(), 7'b01_00000);

        // Wrong press
        bus.esperado = 4'b1000;
        bus.botoes   = 4'b0001;
        tick(LAT);
        chk("t2_wrong", outs_m(), 7'b11_10100);
        bus.botoes = 4'b0000;
        tick(4);

        // Multi-hot press
        bus.botoes = 4'b0011;
        tick(LAT);
        chk("t3_multi", outs_m(), 7'b00_10110);
        bus.botoes = 4'b0000;
        tick(4);

        // Held button gives one play; re-press gives another
        bus.esperado = 4'b0010;
        bus.botoes   = 4'b0010;
        count_valid(50, npulsos);
        chk_int("t5_hold_cnt", npulsos, 1);
        chk("t5_code", outs_m(), 7'b10_00000);
        bus.botoes = 4'b0000;
        tick(4);
        bus.botoes = 4'b0010;
        count_valid(LAT + 3, npulsos);
        chk_int("t5_repress_cnt", npulsos, 1);
        bus.botoes = 4'b0000;
        tick(4);

        // Async reset one edge before capture
        bus.esperado = 4'b0100;
        bus.botoes   = 4'b0100;
        tick(LAT - 1);
        zera_as = 1'b1;
        #1;
        chk("t6_async_now", outs_m(), 7'b00_00000);
        tick(1);
        chk("t6_async_edge", outs_m(), 7'b00_00000);
        bus.botoes = 4'b0000;
        zera_as    = 1'b0;
        tick(4);

        // Drop habilita one edge before capture
        bus.botoes = 4'b0001;
        tick(LAT - 1);
        bus.habilita = 1'b0;
        count_valid(3, npulsos);
        chk_int("t6_hab_cnt", npulsos, 0);
        chk("t6_hab", outs_m(), 7'b00_00000);
        bus.botoes = 4'b0000;
        tick(3);
        bus.habilita = 1'b1;
        tick(2);

        // Synchronous clear after a capture
        bus.botoes = 4'b0001;
        tick(LAT);
        chk("t7_before_clr", outs_m(), 7'b11_10100);
        zera_s = 1'b1;
        #1;
        chk("t7_clr_wait", outs_m(), 7'b11_10100);
        tick(1);
        chk("t7_clr", outs_m(), 7'b00_00000);
        zera_s     = 1'b0;
        bus.botoes = 4'b0000;
        tick(4);

`ifdef DEBOUNCE_EN
        // Glitch rejected, 9-cycle stable press accepted
        bus.botoes = 4'b0100;
        tick(3);
        bus.botoes = 4'b0000;
        count_valid(20, npulsos);
        chk_int("t8_glitch_cnt", npulsos, 0);
        bus.botoes = 4'b0100;
        tick(9);
        bus.botoes = 4'b0000;
        count_valid(10, npulsos);
        chk_int("t8_stable_cnt", npulsos, 1);
        tick(4);
`endif

        // Timeout on the 10-cycle instance
        bus_t.habilita = 1'b1;
        tick(1);
        tick(9);
        chk("t4_before", outs_t(), 7'b00_00000);
        tick(1);
        chk("t4_pulse1", outs_t(), 7'b00_00101);
        tick(1);
        chk("t4_gap", outs_t(), 7'b00_00000);
        tick(9);
        chk("t4_before2", outs_t(), 7'b00_00000);
        tick(1);
        chk("t4_pulse2", outs_t(), 7'b00_00101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
